expansion_timer: RTL and testbench

Programmable 16-bit countdown timer card on the expansion I/O bus, a peer consumer of the bus next to the UART card. The CPU-side design drives strobes, address and data into it; the card returns read data and its own bus output-enable. Bus strobes arrive from the slow design clock domain and are synchronised into the card's single clock. The card provides a software-visible tick source and an expiry interrupt.

---
 rtl/expansion_timer.sv | 190 +++++++++++++++++++
 tb/tb_expansion_timer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/expansion_timer.sv
// expansion_timer: 16-bit countdown timer card on the expansion I/O bus.
// Ports: i_clk100/i_resetn clock and async reset; i_bus/o_bus/o_busNOE
// data path; i_ioNCE/i_ioAddress/i_ioNOE/i_ioNWE bus strobes; o_irq expiry.
module expansion_timer #(
    parameter logic [7:0]  BASE_ADDR = 8'h10,
    parameter int unsigned TICK_DIV  = 100
) (
    input  logic       i_clk100,
    input  logic       i_resetn,
    input  logic [7:0] i_bus,
    output logic [7:0] o_bus,
    output logic       o_busNOE,
    input  logic       i_ioNCE,
    input  logic [7:0] i_ioAddress,
    input  logic       i_ioNOE,
    input  logic       i_ioNWE,
    output logic       o_irq
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    logic [1:0]  nceSync;
    logic [1:0]  noeSync;
    logic [1:0]  nweSync;
    logic        sNce;
    logic        sNoe;
    logic        sNwe;
    logic        nweDly;

    logic        wrHit;
    logic [2:0]  wrOff;
    logic [7:0]  wrData;
    logic        commit;
    logic        wrCtrl;
    logic        wrRldLo;
    logic        wrRldHi;
    logic        wrStatus;

    logic        ctrlEn;
    logic        ctrlAuto;
    logic        ctrlIrqEn;
    logic [7:0]  rldLo;
    logic [7:0]  rldHi;
    logic [15:0] count;
    logic [7:0]  snap;
    logic [15:0] presc;
    logic        exp;

    logic        readHit;
    logic [7:0]  readData;
    logic        tickRaw;
    logic        tick;
    logic        expire;

    assign sNce = nceSync[1];
    assign sNoe = noeSync[1];
    assign sNwe = nweSync[1];

    always_ff @(posedge i_clk100 or negedge i_resetn) begin
        if (!i_resetn) begin
            nceSync <= 2'b11;
            noeSync <= 2'b11;
            nweSync <= 2'b11;
            nweDly  <= 1'b1;
        end else begin
            nceSync <= {nceSync[0], i_ioNCE};
            noeSync <= {noeSync[0], i_ioNOE};
            nweSync <= {nweSync[0], i_ioNWE};
            nweDly  <= sNwe;
        end
    end

    // Address and data are held from the last cycle nWE was seen low,
    // so the commit on the nWE rising edge uses stable values.
    always_ff @(posedge i_clk100 or negedge i_resetn) begin
        if (!i_resetn) begin
            wrHit  <= 1'b0;
            wrOff  <= 3'd0;
            wrData <= 8'h00;
        end else if (!sNwe) begin
            wrHit  <= (i_ioAddress[7:3] == BASE_ADDR[7:3]);
            wrOff  <= i_ioAddress[2:0];
            wrData <= i_bus;
        end
    end

    assign commit   = sNwe && !nweDly && !sNce && wrHit;
    assign wrCtrl   = commit && (wrOff == 3'd0);
    assign wrRldLo  = commit && (wrOff == 3'd1);
    assign wrRldHi  = commit && (wrOff == 3'd2);
    assign wrStatus = commit && (wrOff == 3'd5);

    // A reload-high write or a disabling CTRL write overrides a
    // coincident tick.
    assign tickRaw = ctrlEn && (presc == TICK_LAST);
    assign tick    = tickRaw && !wrRldHi && !(wrCtrl && !wrData[0]);
    assign expire  = tick && (count <= 16'd1);

    always_ff @(posedge i_clk100 or negedge i_resetn) begin
        if (!i_resetn) begin
            ctrlEn    <= 1'b0;
            ctrlAuto  <= 1'b0;
            ctrlIrqEn <= 1'b0;
        end else if (wrCtrl) begin
            ctrlEn    <= wrData[0];
            ctrlAuto  <= wrData[1];
            ctrlIrqEn <= wrData[2];
        end else if (expire) begin
            ctrlEn    <= ctrlAuto;
        end
    end

    always_ff @(posedge i_clk100 or negedge i_resetn) begin
        if (!i_resetn) begin
            rldLo <= 8'h00;
            rldHi <= 8'h00;
        end else begin
            if (wrRldLo) rldLo <= wrData;
            if (wrRldHi) rldHi <= wrData;
        end
    end

    // Prescaler idles at 0 while disabled, so enabling always starts
    // a fresh tick period.
    always_ff @(posedge i_clk100 or negedge i_resetn) begin
        if (!i_resetn) begin
            presc <= 16'd0;
        end else if (wrRldHi || !ctrlEn || tickRaw) begin
            presc <= 16'd0;
        end else begin
            presc <= presc + 16'd1;
        end
    end

    always_ff @(posedge i_clk100 or negedge i_resetn) begin
        if (!i_resetn) begin
            count <= 16'd0;
        end else if (wrRldHi) begin
            count <= {wrData, rldLo};
        end else if (expire) begin
            count <= ctrlAuto ? {rldHi, rldLo} : 16'd0;
        end else if (tick) begin
            count <= count - 16'd1;
        end
    end

    // Expiry beats a same-cycle software clear.
    always_ff @(posedge i_clk100 or negedge i_resetn) begin
        if (!i_resetn) begin
            exp   <= 1'b0;
            o_irq <= 1'b0;
        end else begin
            exp   <= expire || (exp && !(wrStatus && wrData[0]));
            o_irq <= exp && ctrlIrqEn;
        end
    end

    assign readHit = !sNce && !sNoe &&
                     (i_ioAddress[7:3] == BASE_ADDR[7:3]);

    always_comb begin
        readData = 8'h00;
        unique case (i_ioAddress[2:0])
            3'd0:    readData = {5'b0, ctrlIrqEn, ctrlAuto, ctrlEn};
            3'd1:    readData = rldLo;
            3'd2:    readData = rldHi;
            3'd3:    readData = count[7:0];
            3'd4:    readData = snap;
            3'd5:    readData = {7'b0, exp};
            default: readData = 8'h00;
        endcase
    end

    // The high byte is frozen on the first cycle of a CNT_LO read so a
    // following CNT_HI read is coherent with it.
    always_ff @(posedge i_clk100 or negedge i_resetn) begin
        if (!i_resetn) begin
            o_busNOE <= 1'b1;
            o_bus    <= 8'h00;
            snap     <= 8'h00;
        end else begin
            o_busNOE <= !readHit;
            o_bus    <= readHit ? readData : 8'h00;
            if (readHit && o_busNOE && (i_ioAddress[2:0] == 3'd3)) begin
                snap <= count[15:8];
            end
        end
    end

endmodule

// File: tb/tb_expansion_timer.sv
// tb_expansion_timer: self-checking bench for expansion_timer.
// Read data is scoreboarded; timing/irq checks live in each test task.
`timescale 1ns/1ps
module tb_expansion_timer;

    localparam logic [7:0] BASE = 8'h10;

    logic       clk   = 1'b0;
    logic       rstN  = 1'b0;
    logic [7:0] busIn = 8'h00;
    logic [7:0] addr  = 8'h00;
    logic       nCe   = 1'b1;
    logic       nOe   = 1'b1;
    logic       nWe   = 1'b1;
    logic [7:0] busOut;
    logic       busNoe;
    logic       irq;

    int checks = 0;
    int errors = 0;

    logic [7:0] expQ[$];
    string      nameQ[$];
    logic       prevNoe = 1'b1;
    logic [7:0] monExp;
    string      monName;
    logic [7:0] dumpE;
    string      dumpN;

    expansion_timer #(
        .BASE_ADDR(BASE),
        .TICK_DIV (4)
    ) dut (
        .i_clk100   (clk),
        .i_resetn   (rstN),
        .i_bus      (busIn),
        .o_bus      (busOut),
        .o_busNOE   (busNoe),
        .i_ioNCE    (nCe),
        .i_ioAddress(addr),
        .i_ioNOE    (nOe),
        .i_ioNWE    (nWe),
        .o_irq      (irq)
    );

    always #5 clk = ~clk;

    // Scoreboard: every read access pops one expected byte when
    // o_busNOE first falls.
    always @(negedge clk) begin
        if (prevNoe === 1'b1 && busNoe === 1'b0) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL read_unexpected: o_bus=%h, none expected",
                         busOut);
            end else begin
                monExp  = expQ.pop_front();
                monName = nameQ.pop_front();
                if (busOut !== monExp) begin
                    errors++;
                    $display("FAIL %s: o_bus=%h expected %h",
                             monName, busOut, monExp);
                end
            end
        end
        prevNoe = busNoe;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset;
        rstN = 1'b0;
        nCe = 1'b1; nOe = 1'b1; nWe = 1'b1;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
    endtask

    // Returns just after the commit edge (3rd rising edge after nWE rises).
    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; busIn = d; nCe = 1'b0; nWe = 1'b0;
        repeat (2) @(negedge clk);
        nWe = 1'b1;
        repeat (3) @(posedge clk);
        #1 nCe = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] off, input logic [7:0] e,
                            input string nm);
        int n;
        expQ.push_back(e);
        nameQ.push_back(nm);
        @(negedge clk);
        addr = BASE + {5'b0, off}; nCe = 1'b0; nOe = 1'b0;
        n = 0;
        while (busNoe !== 1'b0 && n < 8) begin
            @(negedge clk); n++;
        end
        if (busNoe !== 1'b0) begin
            checks++; errors++;
            $display("FAIL %s: o_busNOE=%b, expected 0 in 8 cycles",
                     nm, busNoe);
            dumpE = expQ.pop_back();
            dumpN = nameQ.pop_back();
        end
        nCe = 1'b1; nOe = 1'b1;
        n = 0;
        while (busNoe !== 1'b1 && n < 8) begin
            @(negedge clk); n++;
        end
        if (busNoe !== 1'b1) begin
            checks++; errors++;
            $display("FAIL %s_release: o_busNOE=%b, expected 1",
                     nm, busNoe);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        int n;
        checks++;
        if (busNoe !== 1'b1 || busOut !== 8'h00 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: noe=%b bus=%h irq=%b, need 1 00 0",
                     busNoe, busOut, irq);
        end
        bus_write(BASE + 8'd2, 8'h00);
        bus_write(BASE, 8'h05);
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_irq: irq=%b expected 1", irq);
        end
        expQ.push_back(8'h04);
        nameQ.push_back("reset_ctrl_before");
        @(negedge clk);
        addr = BASE; nCe = 1'b0; nOe = 1'b0;
        n = 0;
        while (busNoe !== 1'b0 && n < 8) begin
            @(negedge clk); n++;
        end
        checks++;
        if (busNoe !== 1'b0) begin
            errors++;
            $display("FAIL reset_pre_read: noe=%b expected 0", busNoe);
        end
        #2 rstN = 1'b0;
        #1;
        checks++;
        if (busNoe !== 1'b1 || busOut !== 8'h00 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: noe=%b bus=%h irq=%b, need 1 00 0",
                     busNoe, busOut, irq);
        end
        @(negedge clk);
        nCe = 1'b1; nOe = 1'b1; addr = 8'h00;
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus_read(i[2:0], 8'h00, $sformatf("reset_read_%0d", i));
        end
    endtask

    task automatic test_write_readback;
        int n;
        apply_reset();
        bus_write(BASE + 8'd1, 8'h34);
        bus_write(BASE + 8'd2, 8'h12);
        bus_write(BASE, 8'h06);
        bus_read(3'd3, 8'h34, "rb_cnt_lo");
        bus_read(3'd4, 8'h12, "rb_cnt_hi");
        bus_read(3'd0, 8'h06, "rb_ctrl");
        bus_read(3'd1, 8'h34, "rb_rld_lo");
        bus_read(3'd5, 8'h00, "rb_status");
        bus_read(3'd6, 8'h00, "rb_reg6");
        @(negedge clk);
        addr = BASE + 8'd8; nCe = 1'b0; nOe = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (busNoe !== 1'b1) begin
                errors++;
                $display("FAIL rb_foreign_addr: noe=%b expected 1", busNoe);
            end
        end
        nCe = 1'b1; nOe = 1'b1;
        bus_write(BASE + 8'd8, 8'h00);
        bus_read(3'd0, 8'h06, "rb_ctrl_after_foreign_write");
        expQ.push_back(8'h12);
        nameQ.push_back("rb_latency_read");
        @(negedge clk);
        addr = BASE + 8'd2; nCe = 1'b0; nOe = 1'b0;
        n = 0;
        while (busNoe !== 1'b0 && n < 8) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL rb_fall_latency: %0d cycles expected 3", n);
        end
        nCe = 1'b1; nOe = 1'b1;
        n = 0;
        while (busNoe !== 1'b1 && n < 8) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL rb_rise_latency: %0d cycles expected 3", n);
        end
        checks++;
        if (busOut !== 8'h00) begin
            errors++;
            $display("FAIL rb_bus_idle: o_bus=%h expected 00", busOut);
        end
    endtask

    task automatic test_one_shot;
        apply_reset();
        bus_write(BASE + 8'd1, 8'h03);
        bus_write(BASE + 8'd2, 8'h00);
        bus_write(BASE, 8'h05);
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_irq_early: irq=%b expected 0", irq);
        end
        @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_irq: irq=%b expected 1", irq);
        end
        bus_read(3'd5, 8'h01, "oneshot_status");
        bus_read(3'd0, 8'h04, "oneshot_ctrl");
        bus_read(3'd3, 8'h00, "oneshot_count");
    endtask

    task automatic test_auto_reload;
        apply_reset();
        bus_write(BASE + 8'd1, 8'h02);
        bus_write(BASE + 8'd2, 8'h00);
        bus_write(BASE, 8'h07);
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL auto_irq_early: irq=%b expected 0", irq);
        end
        @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL auto_irq_first: irq=%b expected 1", irq);
        end
        bus_write(BASE + 8'd5, 8'h01);
        @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL auto_clear: irq=%b expected 0", irq);
        end
        @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL auto_period_early: irq=%b expected 0", irq);
        end
        @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL auto_period: irq=%b expected 1", irq);
        end
        repeat (2) @(posedge clk);
        bus_write(BASE + 8'd5, 8'h01);
        @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL auto_clear_vs_expiry: irq=%b expected 1", irq);
        end
    endtask

    task automatic test_snapshot;
        apply_reset();
        bus_write(BASE + 8'd1, 8'h00);
        bus_write(BASE + 8'd2, 8'h01);
        bus_write(BASE, 8'h01);
        bus_read(3'd3, 8'h00, "snap_cnt_lo");
        repeat (8) @(posedge clk);
        bus_read(3'd4, 8'h01, "snap_cnt_hi");
    endtask

    task automatic test_strobe_timing;
        int off1;
        int off2;
        apply_reset();
        for (int k = 0; k < 500; k++) begin
            off1 = $urandom_range(1, 9);
            off2 = $urandom_range(1, 9);
            @(posedge clk);
            #(off1);
            addr = BASE; busIn = 8'h05; nCe = 1'b0; nWe = 1'b0;
            repeat (3) @(posedge clk);
            #(off2);
            nWe = 1'b1;
            repeat (3) @(posedge clk);
            #1 nCe = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL strobe_early_%0d: irq=%b expected 0", k, irq);
            end
            @(posedge clk);
            #1;
            checks++;
            if (irq !== 1'b1) begin
                errors++;
                $display("FAIL strobe_commit_%0d: irq=%b expected 1", k, irq);
            end
            bus_write(BASE + 8'd5, 8'h01);
            @(posedge clk);
            #1;
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL strobe_clear_%0d: irq=%b expected 0", k, irq);
            end
        end
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_write_readback();
        test_one_shot();
        test_auto_reload();
        test_snapshot();
        test_strobe_timing();
        repeat (4) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d reads left, expected 0",
                     expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
